// File: rtl/uart_pkg.sv
// Shared UART constants and the frame collector state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // Frame terminator bytes, also used by the transmit data generator.
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Frame collector states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    GOT_CR  = 2'd2,
    DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: pulses expire_o on the cycle the count reaches TIMEOUT_CYC-1.
// Latency: expire_o is combinational from the count register; count restarts after expiry.
// Backpressure: none; clr_i has priority over en_i and suppresses expiry that cycle.
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // TIMEOUT_CYC-1 is the largest value the counter holds.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear on the same cycle wins, so a byte arriving at expiry keeps the frame alive.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: restart on clear, when disabled, or after firing.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || !en_i || expire_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_collector.sv
// Assembles CR LF terminated frames from received bytes into an external buffer at 0..N-1.
// Latency: buffer write and frame_done/frame_err pulses are registered, one cycle after rx_valid.
// Backpressure: none; accepts one byte per cycle, overflow bytes are discarded until LF.
module uart_frame_collector
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic [7:0]        frame_len,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmr_expire;

  // Timer runs only while a frame is open and restarts on every received byte.
  uart_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (rx_valid || (state_q == IDLE)),
    .en_i    (state_q != IDLE),
    .expire_o(tmr_expire)
  );

  // Next state, length counter and registered write/pulse outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_len_d = frame_len_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == ASCII_CR) begin
            len_d   = 8'd0;
            state_d = GOT_CR;
          end else if (rx_data != ASCII_LF) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = rx_data;
            len_d     = 8'd1;
            state_d   = RECV;
          end
        end
        RECV: begin
          if (rx_data == ASCII_CR) begin
            state_d = GOT_CR;
          end else if (len_q == MAX_LEN_B) begin
            state_d = DISCARD;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = len_q[ADDR_W-1:0];
            wr_data_d = rx_data;
            len_d     = len_q + 8'd1;
          end
        end
        GOT_CR: begin
          if (rx_data == ASCII_LF) begin
            // An empty CR LF closes silently.
            if (len_q != 8'd0) begin
              frame_len_d = len_q;
              done_d      = 1'b1;
            end
            state_d = IDLE;
          end else if (rx_data != ASCII_CR) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DISCARD: begin
          if (rx_data == ASCII_LF) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmr_expire) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      frame_len_q <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign frame_len   = frame_len_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_frame_collector.md
Name: uart_frame_collector

Overview:
Receive-side counterpart of the board's UART transmit data generator. It consumes bytes from the UART receiver and assembles CR LF terminated frames (0x0D 0x0A). Payload bytes are written into an external byte buffer at addresses 0..N-1. On completion it reports the payload length N, which the transmit data generator can use as its byte count for echo/loopback.

Parameters:
MAX_LEN, 32, maximum payload bytes per frame (1..255)
ADDR_W, 5, buffer address width; must satisfy 2**ADDR_W >= MAX_LEN
TIMEOUT_CYC, 1000000, idle cycles between bytes before an open frame is aborted (fits 26 bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
buf_wr_en  out  1  buffer write strobe
buf_wr_addr  out  ADDR_W  buffer write address
buf_wr_data  out  8  buffer write data
frame_len  out  8  payload length of last good frame; held until next good frame
frame_done  out  1  one-cycle pulse: good frame complete
frame_err  out  1  one-cycle pulse: frame aborted
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All registers are updated on posedge clk.
- Reset values: every output 0; state IDLE; internal len 0; timer 0. A reset mid-frame drops the frame with no done or err pulse.
- Internal len counter: 8 bits, counts payload bytes of the current frame.
- State IDLE, on rx_valid:
  - 0x0D: go to GOT_CR with len=0.
  - 0x0A: ignore.
  - Any other byte: write it at address 0, set len=1, go to RECV.
- State RECV, on rx_valid:
  - 0x0D: go to GOT_CR.
  - Otherwise, if len==MAX_LEN: overflow; go to DISCARD with no write.
  - Otherwise: write at address len, len+1.
- State GOT_CR, on rx_valid:
  - 0x0A with len>0: frame_len<=len, frame_done=1, go to IDLE.
  - 0x0A with len==0 (empty frame): go to IDLE silently.
  - 0x0D: stay in GOT_CR.
  - Any other byte: frame_err=1, byte dropped, go to IDLE.
- State DISCARD: on rx_valid with 0x0A, frame_err=1 and go to IDLE. All other bytes are dropped.
- Write latency: buf_wr_en/addr/data are registered and assert exactly one cycle after the accepting rx_valid, for one cycle. frame_done and frame_err also assert one cycle after the terminating rx_valid.
- frame_len updates in the same cycle frame_done asserts.
- Idle timeout:
  - The timer counts only in RECV, GOT_CR and DISCARD, and clears on every rx_valid and in IDLE.
  - When the timer reaches TIMEOUT_CYC-1: frame_err=1 next cycle, go to IDLE.
  - If rx_valid and timer expiry coincide, rx_valid wins: the byte is processed and the timer cleared.
- frame_done and frame_err never assert in the same cycle.
- frame_len is unchanged by errors.
- Bytes arrive no faster than one per UART character time. Back-to-back rx_valid on consecutive cycles must still be handled correctly, one byte per cycle.

Decomposition:
- Shared package uart_pkg: ASCII_CR=8'h0D, ASCII_LF=8'h0A, and the state encoding (IDLE, RECV, GOT_CR, DISCARD) as a typedef/localparams. The transmit data generator reuses the CR/LF constants.
- One natural sub-module, uart_idle_timer: clear/enable inputs, expire pulse output, parameter TIMEOUT_CYC.
- The FSM, len counter and write port stay in the top module.

Test Plan:
- "AB" 0D 0A → writes (0,0x41),(1,0x42); frame_done one cycle after LF; frame_len=2; no frame_err.
- 32 bytes 0x30..0x4F then 0D 0A (MAX_LEN=32) → 32 writes at addresses 0..31; frame_len=32. Repeat with 33 bytes → 32 writes, no write for byte 33, frame_err on LF, frame_len keeps its previous value.
- 0D 0A alone; then 0A alone in IDLE → no writes, no pulses, busy returns to 0.
- "X" 0D "Y" → write (0,0x58); frame_err one cycle after "Y"; "Y" not written; IDLE.
- "Q", then no rx_valid for TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in bench) → frame_err exactly at expiry+1, busy=0. Repeat with rx_valid landing on the expiry cycle → no err, byte written.
- rst asserted after "AB" mid-frame, then "C" 0D 0A → no pulse from the first frame; write (0,0x43); frame_len=1.
